// File: rtl/arm_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// arm_hazard_scoreboard
//
// Hazard / flush controller for the ARM pipeline. Destination tags of the
// instructions that have left ID are tracked in a shifting scoreboard
// (slot 0 = EXE, slot DEPTH-1 = last stage before the register-file write).
// A read-after-write match against the ID operands raises freeze. A taken
// branch raises flush for FLUSH_CYCLES cycles.
//
// Optional feature, macro ARM_HAZARD_FORWARDING_EN:
//   defined   - forwarding selects are produced and only load-use stalls.
//   undefined - every RAW match stalls and the forwarding selects are 0.
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   asynchronous reset, active-low
//   issue_valid   in   ID stage holds a valid instruction
//   src_1         in   Rn tag of the ID instruction
//   src_2         in   Rm/Rd tag of the ID instruction
//   two_src       in   src_2 is a real operand
//   dest_id       in   destination tag of the ID instruction
//   wb_en_id      in   ID instruction writes dest_id
//   mem_r_en_id   in   ID instruction is a load
//   branch_taken  in   branch resolved taken in EXE this cycle
//   freeze        out  stall PC and IF/ID, insert a bubble
//   flush         out  kill IF/ID and ID/EXE contents
//   fwd_sel_1     out  operand-1 source: 0 = reg file, k+1 = slot k
//   fwd_sel_2     out  operand-2 source, same encoding
//   stall_cnt     out  saturating count of frozen cycles
// -----------------------------------------------------------------------------
module arm_hazard_scoreboard #(
  parameter int REG_ADDR_W   = 4,
  parameter int DEPTH        = 3,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16,
  localparam int SEL_W       = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] src_1,
  input  logic [REG_ADDR_W-1:0] src_2,
  input  logic                  two_src,
  input  logic [REG_ADDR_W-1:0] dest_id,
  input  logic                  wb_en_id,
  input  logic                  mem_r_en_id,
  input  logic                  branch_taken,
  output logic                  freeze,
  output logic                  flush,
  output logic [SEL_W-1:0]      fwd_sel_1,
  output logic [SEL_W-1:0]      fwd_sel_2,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int FC_W = 4;

  logic [DEPTH-1:0]      slot_vld;
  logic [REG_ADDR_W-1:0] slot_dest [DEPTH];
  logic [DEPTH-1:0]      slot_load;
  logic [DEPTH-1:0]      hit1;
  logic [DEPTH-1:0]      hit2;
  logic [FC_W-1:0]       flush_cnt;
  logic                  slot_enter;

  always_comb begin
    hit1 = '0;
    hit2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      hit1[k] = issue_valid & slot_vld[k] & (slot_dest[k] == src_1);
      hit2[k] = issue_valid & two_src & slot_vld[k] & (slot_dest[k] == src_2);
    end
  end

  // The branch cycle itself flushes; the counter covers the cycles after it.
  assign flush = branch_taken | (flush_cnt != '0);

`ifdef ARM_HAZARD_FORWARDING_EN
  // Only a load in EXE cannot be forwarded in time: one bubble.
  assign freeze = !flush & ((hit1[0] | hit2[0]) & slot_load[0]);

  // Scan oldest to youngest so the youngest producer overrides.
  always_comb begin
    fwd_sel_1 = '0;
    fwd_sel_2 = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (hit1[k]) fwd_sel_1 = SEL_W'(k + 1);
      if (hit2[k]) fwd_sel_2 = SEL_W'(k + 1);
    end
    if (flush) begin
      fwd_sel_1 = '0;
      fwd_sel_2 = '0;
    end
  end
`else
  assign freeze    = !flush & ((|hit1) | (|hit2));
  assign fwd_sel_1 = '0;
  assign fwd_sel_2 = '0;

  // Load flags only matter when forwarding hides the other hazards.
  logic unused_load;
  assign unused_load = ^slot_load;
`endif

  // Frozen or flushed ID instructions become a bubble in EXE.
  assign slot_enter = issue_valid & wb_en_id & !freeze & !flush;

  // ---- ID -> EXE .. WB boundary: control part of the scoreboard ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_vld  <= '0;
      flush_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      slot_vld[0] <= slot_enter;
      for (int k = 1; k < DEPTH; k++) slot_vld[k] <= slot_vld[k-1];

      if (branch_taken)          flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
      else if (flush_cnt != '0)  flush_cnt <= flush_cnt - FC_W'(1);

      if (freeze && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // ---- ID -> EXE .. WB boundary: tag payload, qualified by slot_vld ----
  always_ff @(posedge clk) begin
    slot_dest[0] <= dest_id;
    slot_load[0] <= mem_r_en_id;
    for (int k = 1; k < DEPTH; k++) begin
      slot_dest[k] <= slot_dest[k-1];
      slot_load[k] <= slot_load[k-1];
    end
  end

endmodule

// File: tb/tb_arm_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_arm_hazard_scoreboard
//
// Directed bench for arm_hazard_scoreboard (DEPTH=3, FLUSH_CYCLES=2, CNT_W=3
// so the stall counter saturates within a short run). Each step drives the ID
// inputs just after a rising edge, queues the hand-derived expected outputs and
// compares them against the DUT on the following falling edge. Expectations
// follow the forwarding variant when ARM_HAZARD_FORWARDING_EN is defined.
// -----------------------------------------------------------------------------
module tb_arm_hazard_scoreboard;

  localparam int RW    = 4;
  localparam int DEPTH = 3;
  localparam int FC    = 2;
  localparam int CW    = 3;
  localparam int SW    = 2;

`ifdef ARM_HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          issue_valid = 1'b0;
  logic [RW-1:0] src_1 = '0;
  logic [RW-1:0] src_2 = '0;
  logic          two_src = 1'b0;
  logic [RW-1:0] dest_id = '0;
  logic          wb_en_id = 1'b0;
  logic          mem_r_en_id = 1'b0;
  logic          branch_taken = 1'b0;
  logic          freeze;
  logic          flush;
  logic [SW-1:0] fwd_sel_1;
  logic [SW-1:0] fwd_sel_2;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  arm_hazard_scoreboard #(
    .REG_ADDR_W  (RW),
    .DEPTH       (DEPTH),
    .FLUSH_CYCLES(FC),
    .CNT_W       (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .src_1       (src_1),
    .src_2       (src_2),
    .two_src     (two_src),
    .dest_id     (dest_id),
    .wb_en_id    (wb_en_id),
    .mem_r_en_id (mem_r_en_id),
    .branch_taken(branch_taken),
    .freeze      (freeze),
    .flush       (flush),
    .fwd_sel_1   (fwd_sel_1),
    .fwd_sel_2   (fwd_sel_2),
    .stall_cnt   (stall_cnt)
  );

  typedef struct packed {
    logic          fr;
    logic          fl;
    logic [SW-1:0] f1;
    logic [SW-1:0] f2;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [CW-1:0] sat(input int n);
    return (n > 7) ? CW'(7) : CW'(n);
  endfunction

  function automatic exp_t ex(input logic fr, input logic fl, input int f1,
                              input int f2, input int cnt);
    exp_t e;
    e.fr  = fr;
    e.fl  = fl;
    e.f1  = SW'(f1);
    e.f2  = SW'(f2);
    e.cnt = sat(cnt);
    return e;
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    tests++;
    assert (got === want)
      else begin
        fails++;
        $error("FAIL %s: observed %0h expected %0h", tag, got, want);
      end
  endtask

  // Pop the oldest expectation and compare every output against it.
  task automatic compare_out(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    check({name, ".freeze"},    8'(freeze),    8'(e.fr));
    check({name, ".flush"},     8'(flush),     8'(e.fl));
    check({name, ".fwd_sel_1"}, 8'(fwd_sel_1), 8'(e.f1));
    check({name, ".fwd_sel_2"}, 8'(fwd_sel_2), 8'(e.f2));
    check({name, ".stall_cnt"}, 8'(stall_cnt), 8'(e.cnt));
  endtask

  task automatic drive(input logic iv, input logic [RW-1:0] s1, input logic [RW-1:0] s2,
                       input logic two, input logic [RW-1:0] d, input logic wb,
                       input logic ld, input logic br);
    issue_valid  = iv;
    src_1        = s1;
    src_2        = s2;
    two_src      = two;
    dest_id      = d;
    wb_en_id     = wb;
    mem_r_en_id  = ld;
    branch_taken = br;
  endtask

  task automatic step(input string name, input logic iv, input logic [RW-1:0] s1,
                      input logic [RW-1:0] s2, input logic two, input logic [RW-1:0] d,
                      input logic wb, input logic ld, input logic br, input exp_t e);
    drive(iv, s1, s2, two, d, wb, ld, br);
    sb.push_back(e);
    @(negedge clk);
    compare_out(name);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int nf;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    sb.push_back(ex(0, 0, 0, 0, 0));
    compare_out("reset");
    @(posedge clk);
    #1 rst = 1'b1;

`ifdef ARM_HAZARD_FORWARDING_EN
    //    name    iv s1 s2 two d  wb ld br   fr fl f1 f2 cnt
    step("add_r1", 1, 2, 3, 1, 1, 1, 0, 0, ex(0, 0, 0, 0, 0));
    step("sub_r1", 1, 1, 5, 1, 4, 1, 0, 0, ex(0, 0, 1, 0, 0));
    step("bubble", 0, 1, 4, 1, 0, 0, 0, 0, ex(0, 0, 0, 0, 0));
    step("fwd_old",1, 1, 4, 1, 0, 0, 0, 0, ex(0, 0, 3, 2, 0));
    step("ldr_r2", 1, 0, 0, 0, 2, 1, 1, 0, ex(0, 0, 0, 0, 0));
    step("ld_use", 1, 7, 2, 1, 8, 1, 0, 0, ex(1, 0, 0, 1, 0));
    step("ld_fwd", 1, 7, 2, 1, 8, 1, 0, 0, ex(0, 0, 0, 2, 1));
    step("one_src",1, 0, 8, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 1));
    step("rewr_r8",1, 8, 0, 0, 8, 1, 0, 0, ex(0, 0, 2, 0, 1));
    step("young",  1, 8, 0, 0, 0, 0, 0, 0, ex(0, 0, 1, 0, 1));
    step("br_a",   1, 8, 0, 0, 9, 1, 0, 1, ex(0, 1, 0, 0, 1));
    step("br_tail",1, 8, 0, 0, 0, 0, 0, 0, ex(0, 1, 0, 0, 1));
    step("br_done",1, 0, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 1));
    step("ldr_r3", 1, 0, 0, 0, 3, 1, 1, 0, ex(0, 0, 0, 0, 1));
    drive(1, 3, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    sb.push_back(ex(1, 0, 1, 0, 1));
    compare_out("pre_rst");
`else
    //    name    iv s1 s2 two d  wb ld br   fr fl f1 f2 cnt
    step("add_r1", 1, 2, 3, 1, 1, 1, 0, 0, ex(0, 0, 0, 0, 0));
    step("sub_e0", 1, 1, 5, 1, 4, 1, 0, 0, ex(1, 0, 0, 0, 0));
    step("sub_e1", 1, 1, 5, 1, 4, 1, 0, 0, ex(1, 0, 0, 0, 1));
    step("sub_e2", 1, 1, 5, 1, 4, 1, 0, 0, ex(1, 0, 0, 0, 2));
    step("sub_go", 1, 1, 5, 1, 4, 1, 0, 0, ex(0, 0, 0, 0, 3));
    step("one_src",1, 7, 4, 0, 6, 1, 0, 0, ex(0, 0, 0, 0, 3));
    step("src2",   1, 0, 6, 1, 0, 0, 0, 0, ex(1, 0, 0, 0, 3));
    step("no_iv",  0, 6, 6, 1, 0, 0, 0, 0, ex(0, 0, 0, 0, 4));
    step("wr_pc",  1, 0, 0, 0, 15,1, 0, 0, ex(0, 0, 0, 0, 4));
    step("br_a",   1, 15,0, 0, 0, 0, 0, 1, ex(0, 1, 0, 0, 4));
    step("br_b",   1, 15,0, 0, 0, 0, 0, 1, ex(0, 1, 0, 0, 4));
    step("br_tail",1, 15,0, 0, 0, 0, 0, 0, ex(0, 1, 0, 0, 4));
    step("br_done",1, 15,0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 4));
    step("add_r3", 1, 0, 0, 0, 3, 1, 0, 0, ex(0, 0, 0, 0, 4));
    drive(1, 3, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    sb.push_back(ex(1, 0, 0, 0, 4));
    compare_out("pre_rst");
`endif

    // Reset asserted in the middle of a freeze clears without a clock edge.
    #2 rst = 1'b0;
    #1;
    sb.push_back(ex(0, 0, 0, 0, 0));
    compare_out("rst_async");
    @(posedge clk);
    #1 rst = 1'b1;
    step("post_rst", 1, 3, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0));

    // Repeated hazards drive stall_cnt into saturation.
    nf   = FWD ? 1 : 3;
    base = 0;
    for (int r = 0; r < 8; r++) begin
      step("sat_prod", 1, 0, 0, 0, 3, 1, 1, 0, ex(0, 0, 0, 0, base));
      for (int j = 0; j < nf; j++) begin
        step("sat_use", 1, 0, 3, 1, 0, 0, 0, 0, ex(1, 0, 0, FWD ? 1 : 0, base));
        base++;
      end
    end
    step("sat_hold", 0, 0, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, base));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
